// File: rtl/ram_to_stream_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ram_to_stream_pkg
// Brief   : Shared state encoding, default RAM geometry and helpers for the
//           ram_to_stream read-back stage.
// Revision: 1.0 - initial release
// ============================================================================
package ram_to_stream_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FINISH = 2'd2
    } rts_state_e;

    // Default geometry matches the capture side; instantiations may override.
    localparam int          C_DEF_CYCLES_PER_RAM_BLOCK = 64;
    localparam logic [63:0] C_DEF_RAM_BLOCK_SIZE       = 64'd4096;
    localparam int          C_DEF_RAM_BLOCKS_PER_BANK  = 1024;
    localparam logic [63:0] C_DEF_BANK0_BASE_ADDR      = 64'h0000_0000_0000_0000;
    localparam logic [63:0] C_DEF_BANK1_BASE_ADDR      = 64'h0000_0001_0000_0000;
    localparam logic [63:0] C_DEF_BANK2_BASE_ADDR      = 64'h0000_0002_0000_0000;
    localparam logic [63:0] C_DEF_BANK3_BASE_ADDR      = 64'h0000_0003_0000_0000;

    function automatic logic [31:0] clamp_blocks(input logic [31:0] req,
                                                 input logic [31:0] limit);
        return (req < limit) ? req : limit;
    endfunction

    function automatic logic [63:0] bank_base(input int          channel,
                                              input logic [63:0] b0,
                                              input logic [63:0] b1,
                                              input logic [63:0] b2,
                                              input logic [63:0] b3);
        case (channel)
            0:       return b0;
            1:       return b1;
            2:       return b2;
            3:       return b3;
            default: return 64'd0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/ram_to_stream_fifo.sv
`default_nettype none
// ============================================================================
// Module  : ram_to_stream_fifo
// Brief   : Common-clock first-word-fall-through AXIS data FIFO with a
//           registered output stage and a synchronous flush.
// Revision: 1.0 - initial release
// ============================================================================
module ram_to_stream_fifo #(
    parameter int DW    = 512,
    parameter int DEPTH = 256
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush_i,
    input  logic [DW-1:0] s_tdata_i,
    input  logic          s_tvalid_i,
    output logic [DW-1:0] m_tdata_o,
    output logic          m_tvalid_o,
    input  logic          m_tready_i
);

    localparam int             AW          = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int             CW          = $clog2(DEPTH) + 1;
    localparam logic [AW-1:0]  C_LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [CW-1:0]  C_DEPTH     = CW'(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [DW-1:0] dout_q, dout_d;
    logic          valid_q, valid_d;
    logic          push;
    logic          load;

    always_comb begin
        push     = s_tvalid_i && (count_q != C_DEPTH);
        // Refill the output register whenever it is empty or being consumed.
        load     = (count_q != '0) && (!valid_q || m_tready_i);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        dout_d   = dout_q;
        valid_d  = valid_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            valid_d  = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_d = (wr_ptr_q == C_LAST_ADDR) ? '0 : wr_ptr_q + 1'b1;
            end
            if (load) begin
                rd_ptr_d = (rd_ptr_q == C_LAST_ADDR) ? '0 : rd_ptr_q + 1'b1;
                dout_d   = mem_q[rd_ptr_q];
                valid_d  = 1'b1;
            end else if (m_tready_i) begin
                valid_d  = 1'b0;
            end
            count_d = count_q + CW'(push) - CW'(load);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= s_tdata_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            dout_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            dout_q   <= dout_d;
            valid_q  <= valid_d;
        end
    end

    assign m_tdata_o  = dout_q;
    assign m_tvalid_o = valid_q;

endmodule
`default_nettype wire

// File: rtl/ram_to_stream.sv
`default_nettype none
// ============================================================================
// Module  : ram_to_stream
// Brief   : Reads committed RAM blocks of one bank over AXI4 and emits one
//           TLAST-framed AXI-Stream packet per block, flow-controlled by credit.
// Revision: 1.0 - initial release
// ============================================================================
module ram_to_stream
    import ram_to_stream_pkg::*;
#(
    parameter int          DW                   = 512,
    parameter int          CHANNEL              = 0,
    parameter int          FIFO_DEPTH           = 256,
    parameter int          CYCLES_PER_RAM_BLOCK = C_DEF_CYCLES_PER_RAM_BLOCK,
    parameter logic [63:0] RAM_BLOCK_SIZE       = C_DEF_RAM_BLOCK_SIZE,
    parameter int          RAM_BLOCKS_PER_BANK  = C_DEF_RAM_BLOCKS_PER_BANK,
    parameter logic [63:0] BANK0_BASE_ADDR      = C_DEF_BANK0_BASE_ADDR,
    parameter logic [63:0] BANK1_BASE_ADDR      = C_DEF_BANK1_BASE_ADDR,
    parameter logic [63:0] BANK2_BASE_ADDR      = C_DEF_BANK2_BASE_ADDR,
    parameter logic [63:0] BANK3_BASE_ADDR      = C_DEF_BANK3_BASE_ADDR
) (
    input  logic          clk,
    input  logic          sys_resetn,
    input  logic          start,
    input  logic [31:0]   block_count,
    input  logic [31:0]   blocks_available,
    output logic          busy,
    output logic          done,
    output logic [31:0]   blocks_read,
    output logic          read_error,
    output logic [DW-1:0] AXIS_OUT_TDATA,
    output logic          AXIS_OUT_TVALID,
    output logic          AXIS_OUT_TLAST,
    input  logic          AXIS_OUT_TREADY,
    output logic [63:0]   M_AXI_ARADDR,
    output logic [7:0]    M_AXI_ARLEN,
    output logic [2:0]    M_AXI_ARSIZE,
    output logic [1:0]    M_AXI_ARBURST,
    output logic [3:0]    M_AXI_ARID,
    output logic          M_AXI_ARLOCK,
    output logic [3:0]    M_AXI_ARCACHE,
    output logic [3:0]    M_AXI_ARQOS,
    output logic [2:0]    M_AXI_ARPROT,
    output logic          M_AXI_ARVALID,
    input  logic          M_AXI_ARREADY,
    input  logic [DW-1:0] M_AXI_RDATA,
    input  logic [1:0]    M_AXI_RRESP,
    input  logic          M_AXI_RLAST,
    input  logic          M_AXI_RVALID,
    output logic          M_AXI_RREADY
);

    localparam int             RW                = $clog2(FIFO_DEPTH) + 1;
    localparam int             BW                = $clog2(CYCLES_PER_RAM_BLOCK) + 1;
    localparam logic [63:0]    C_BASE            = bank_base(CHANNEL, BANK0_BASE_ADDR,
                                                             BANK1_BASE_ADDR, BANK2_BASE_ADDR,
                                                             BANK3_BASE_ADDR);
    localparam logic [31:0]    C_BLOCKS_PER_BANK = 32'(RAM_BLOCKS_PER_BANK);
    localparam logic [BW-1:0]  C_LAST_BEAT       = BW'(CYCLES_PER_RAM_BLOCK - 1);
    localparam logic [RW-1:0]  C_BLOCK_CREDIT    = RW'(CYCLES_PER_RAM_BLOCK);
    localparam logic [RW:0]    C_DEPTH           = (RW + 1)'(FIFO_DEPTH);

    // Asynchronous assert, synchronous release.
    logic [1:0] rst_sync_q;
    logic       rst_n;

    always_ff @(posedge clk or negedge sys_resetn) begin
        if (!sys_resetn) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n = rst_sync_q[1];

    rts_state_e    state_q, state_d;
    logic [31:0]   target_q, target_d;
    logic [31:0]   ar_blocks_q, ar_blocks_d;
    logic [31:0]   blocks_read_q, blocks_read_d;
    logic [63:0]   araddr_q, araddr_d;
    logic          arvalid_q, arvalid_d;
    logic [RW-1:0] reserved_q, reserved_d;
    logic [BW-1:0] beat_q, beat_d;
    logic          read_error_q, read_error_d;

    logic          flush;
    logic          ar_hs;
    logic          ax_hs;
    logic          r_hs;
    logic          credit_ok;
    logic [31:0]   start_target;
    logic [DW-1:0] fifo_tdata;
    logic          fifo_tvalid;
    logic          rlast_unused;

    assign M_AXI_RREADY = rst_n;
    assign ar_hs        = arvalid_q && M_AXI_ARREADY;
    assign ax_hs        = fifo_tvalid && AXIS_OUT_TREADY;
    assign r_hs         = M_AXI_RVALID && M_AXI_RREADY;
    assign credit_ok    = ({1'b0, reserved_q} + {1'b0, C_BLOCK_CREDIT}) <= C_DEPTH;
    assign start_target = clamp_blocks(block_count, C_BLOCKS_PER_BANK);
    // Framing comes from the local beat counter, not from the slave.
    assign rlast_unused = M_AXI_RLAST;

    always_comb begin
        state_d       = state_q;
        target_d      = target_q;
        ar_blocks_d   = ar_blocks_q;
        blocks_read_d = blocks_read_q;
        araddr_d      = araddr_q;
        arvalid_d     = arvalid_q;
        reserved_d    = reserved_q;
        beat_d        = beat_q;
        read_error_d  = read_error_q;
        flush         = 1'b0;

        if (r_hs && (M_AXI_RRESP != 2'b00)) begin
            read_error_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    target_d      = start_target;
                    ar_blocks_d   = '0;
                    blocks_read_d = '0;
                    read_error_d  = 1'b0;
                    araddr_d      = C_BASE;
                    arvalid_d     = 1'b0;
                    reserved_d    = '0;
                    beat_d        = '0;
                    flush         = 1'b1;
                    state_d       = (start_target == '0) ? ST_FINISH : ST_RUN;
                end
            end
            ST_RUN: begin
                if (arvalid_q) begin
                    if (M_AXI_ARREADY) begin
                        arvalid_d   = 1'b0;
                        ar_blocks_d = ar_blocks_q + 32'd1;
                        araddr_d    = araddr_q + RAM_BLOCK_SIZE;
                    end
                end else if ((ar_blocks_q < target_q) &&
                             (ar_blocks_q < blocks_available) && credit_ok) begin
                    arvalid_d = 1'b1;
                end

                reserved_d = reserved_q + (ar_hs ? C_BLOCK_CREDIT : '0)
                           - {{(RW - 1){1'b0}}, ax_hs};

                if (ax_hs) begin
                    if (beat_q == C_LAST_BEAT) begin
                        beat_d        = '0;
                        blocks_read_d = blocks_read_q + 32'd1;
                    end else begin
                        beat_d        = beat_q + 1'b1;
                    end
                end

                if (blocks_read_d == target_q) begin
                    state_d = ST_FINISH;
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            target_q      <= '0;
            ar_blocks_q   <= '0;
            blocks_read_q <= '0;
            araddr_q      <= C_BASE;
            arvalid_q     <= 1'b0;
            reserved_q    <= '0;
            beat_q        <= '0;
            read_error_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            target_q      <= target_d;
            ar_blocks_q   <= ar_blocks_d;
            blocks_read_q <= blocks_read_d;
            araddr_q      <= araddr_d;
            arvalid_q     <= arvalid_d;
            reserved_q    <= reserved_d;
            beat_q        <= beat_d;
            read_error_q  <= read_error_d;
        end
    end

    ram_to_stream_fifo #(
        .DW    (DW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush_i    (flush),
        .s_tdata_i  (M_AXI_RDATA),
        .s_tvalid_i (r_hs),
        .m_tdata_o  (fifo_tdata),
        .m_tvalid_o (fifo_tvalid),
        .m_tready_i (AXIS_OUT_TREADY)
    );

    assign busy            = (state_q == ST_RUN);
    assign done            = (state_q == ST_FINISH);
    assign blocks_read     = blocks_read_q;
    assign read_error      = read_error_q;

    assign AXIS_OUT_TDATA  = fifo_tdata;
    assign AXIS_OUT_TVALID = fifo_tvalid;
    assign AXIS_OUT_TLAST  = fifo_tvalid && (beat_q == C_LAST_BEAT);

    assign M_AXI_ARADDR    = araddr_q;
    assign M_AXI_ARVALID   = arvalid_q;
    assign M_AXI_ARLEN     = 8'(CYCLES_PER_RAM_BLOCK - 1);
    assign M_AXI_ARSIZE    = 3'($clog2(DW / 8));
    assign M_AXI_ARBURST   = 2'b01;
    assign M_AXI_ARID      = 4'd0;
    assign M_AXI_ARLOCK    = 1'b0;
    assign M_AXI_ARCACHE   = 4'd0;
    assign M_AXI_ARQOS     = 4'd0;
    assign M_AXI_ARPROT    = 3'd0;

endmodule
`default_nettype wire

// File: tb/tb_ram_to_stream.sv
`default_nettype none
// ============================================================================
// Module  : tb_ram_to_stream
// Brief   : Self-checking bench for ram_to_stream with an AXI4 read slave
//           whose RAM content equals the byte address of each beat.
// Revision: 1.0 - initial release
// ============================================================================
module tb_ram_to_stream;

    localparam int          DW  = 64;
    localparam int          CPB = 4;
    localparam int          BPB = 8;
    localparam int          FD  = 16;
    localparam logic [63:0] BASE = 64'h1000;
    localparam logic [63:0] BSZ  = 64'd256;

    logic          clk = 1'b0;
    logic          sys_resetn;
    logic          start;
    logic [31:0]   block_count;
    logic [31:0]   blocks_available;
    logic          busy, done, read_error;
    logic [31:0]   blocks_read;
    logic [DW-1:0] AXIS_OUT_TDATA;
    logic          AXIS_OUT_TVALID, AXIS_OUT_TLAST, AXIS_OUT_TREADY;
    logic [63:0]   M_AXI_ARADDR;
    logic [7:0]    M_AXI_ARLEN;
    logic [2:0]    M_AXI_ARSIZE, M_AXI_ARPROT;
    logic [1:0]    M_AXI_ARBURST, M_AXI_RRESP;
    logic [3:0]    M_AXI_ARID, M_AXI_ARCACHE, M_AXI_ARQOS;
    logic          M_AXI_ARLOCK, M_AXI_ARVALID, M_AXI_ARREADY;
    logic [DW-1:0] M_AXI_RDATA;
    logic          M_AXI_RLAST, M_AXI_RVALID, M_AXI_RREADY;

    always #5 clk = ~clk;

    ram_to_stream #(
        .DW                   (DW),
        .CHANNEL              (0),
        .FIFO_DEPTH           (FD),
        .CYCLES_PER_RAM_BLOCK (CPB),
        .RAM_BLOCK_SIZE       (BSZ),
        .RAM_BLOCKS_PER_BANK  (BPB),
        .BANK0_BASE_ADDR      (BASE)
    ) dut (
        .clk              (clk),
        .sys_resetn       (sys_resetn),
        .start            (start),
        .block_count      (block_count),
        .blocks_available (blocks_available),
        .busy             (busy),
        .done             (done),
        .blocks_read      (blocks_read),
        .read_error       (read_error),
        .AXIS_OUT_TDATA   (AXIS_OUT_TDATA),
        .AXIS_OUT_TVALID  (AXIS_OUT_TVALID),
        .AXIS_OUT_TLAST   (AXIS_OUT_TLAST),
        .AXIS_OUT_TREADY  (AXIS_OUT_TREADY),
        .M_AXI_ARADDR     (M_AXI_ARADDR),
        .M_AXI_ARLEN      (M_AXI_ARLEN),
        .M_AXI_ARSIZE     (M_AXI_ARSIZE),
        .M_AXI_ARBURST    (M_AXI_ARBURST),
        .M_AXI_ARID       (M_AXI_ARID),
        .M_AXI_ARLOCK     (M_AXI_ARLOCK),
        .M_AXI_ARCACHE    (M_AXI_ARCACHE),
        .M_AXI_ARQOS      (M_AXI_ARQOS),
        .M_AXI_ARPROT     (M_AXI_ARPROT),
        .M_AXI_ARVALID    (M_AXI_ARVALID),
        .M_AXI_ARREADY    (M_AXI_ARREADY),
        .M_AXI_RDATA      (M_AXI_RDATA),
        .M_AXI_RRESP      (M_AXI_RRESP),
        .M_AXI_RLAST      (M_AXI_RLAST),
        .M_AXI_RVALID     (M_AXI_RVALID),
        .M_AXI_RREADY     (M_AXI_RREADY)
    );

    int          errors = 0;
    int          checks = 0;
    int          ar_n, out_n, done_n;
    logic [63:0] last_araddr;
    int          tready_mode;
    int          err_blk, err_beat;

    typedef struct {
        int          bc;
        int          av;
        int          mode;
        int          eblk;
        int          ebeat;
        int          exp_ars;
        logic [63:0] exp_last;
        int          exp_br;
        logic        exp_err;
    } vec_t;

    vec_t tbl [6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // AXI read slave and output monitor share one cycle loop.
    initial begin
        logic        ar_f, r_f, ax_f;
        logic [63:0] ar_a, tmp;
        logic        pv_ax_stall, pv_ar_stall;
        logic [63:0] pv_tdata, pv_araddr;
        logic [63:0] q [$];
        int          rbeat;
        rbeat = 0; pv_ax_stall = 0; pv_ar_stall = 0; pv_tdata = '0; pv_araddr = '0;
        M_AXI_ARREADY = 0; M_AXI_RVALID = 0; M_AXI_RDATA = '0; M_AXI_RRESP = 0;
        M_AXI_RLAST = 0; AXIS_OUT_TREADY = 1;
        forever begin
            @(negedge clk);
            ar_f = M_AXI_ARVALID && M_AXI_ARREADY;
            r_f  = M_AXI_RVALID && M_AXI_RREADY;
            ax_f = AXIS_OUT_TVALID && AXIS_OUT_TREADY;
            ar_a = M_AXI_ARADDR;
            if (sys_resetn) begin
                if (pv_ax_stall) begin
                    check("tvalid_held", AXIS_OUT_TVALID, 1);
                    check("tdata_stable", AXIS_OUT_TDATA, pv_tdata);
                end
                if (pv_ar_stall) begin
                    check("arvalid_held", M_AXI_ARVALID, 1);
                    check("araddr_stable", M_AXI_ARADDR, pv_araddr);
                end
                if (ar_f) begin
                    check("araddr", ar_a, BASE + BSZ * 64'(ar_n));
                    last_araddr = ar_a;
                    ar_n++;
                end
                if (ax_f) begin
                    check("tdata", AXIS_OUT_TDATA,
                          BASE + BSZ * 64'(out_n / CPB) + 64'(8 * (out_n % CPB)));
                    check("tlast", AXIS_OUT_TLAST, 64'((out_n % CPB) == CPB - 1));
                    out_n++;
                end
                if (done) done_n++;
                pv_ax_stall = AXIS_OUT_TVALID && !AXIS_OUT_TREADY;
                pv_tdata    = AXIS_OUT_TDATA;
                pv_ar_stall = M_AXI_ARVALID && !M_AXI_ARREADY;
                pv_araddr   = M_AXI_ARADDR;
            end else begin
                pv_ax_stall = 0;
                pv_ar_stall = 0;
            end

            @(posedge clk);
            #1;
            case (tready_mode)
                0:       AXIS_OUT_TREADY = 1'b1;
                1:       AXIS_OUT_TREADY = 1'b0;
                default: AXIS_OUT_TREADY = 1'($urandom_range(0, 1));
            endcase
            if (!sys_resetn) begin
                q.delete();
                rbeat = 0;
                M_AXI_RVALID = 0; M_AXI_ARREADY = 0; M_AXI_RLAST = 0; M_AXI_RRESP = 0;
            end else begin
                if (ar_f) q.push_back(ar_a);
                if (r_f) begin
                    if (rbeat == CPB - 1) begin
                        tmp = q.pop_front();
                        rbeat = 0;
                    end else begin
                        rbeat++;
                    end
                end
                M_AXI_ARREADY = 1'($urandom_range(0, 1));
                if (q.size() > 0 && $urandom_range(0, 3) != 0) begin
                    M_AXI_RVALID = 1;
                    M_AXI_RDATA  = q[0] + 64'(8 * rbeat);
                    M_AXI_RLAST  = (rbeat == CPB - 1);
                    M_AXI_RRESP  = (err_blk >= 0 && q[0] == BASE + BSZ * 64'(err_blk) &&
                                    rbeat == err_beat) ? 2'b10 : 2'b00;
                end else begin
                    M_AXI_RVALID = 0;
                    M_AXI_RRESP  = 0;
                end
            end
        end
    end

    task automatic do_start(input int bc);
        @(posedge clk);
        #1;
        ar_n = 0; out_n = 0; done_n = 0; last_araddr = '0;
        block_count = 32'(bc);
        start = 1;
        @(posedge clk);
        #1;
        start = 0;
        check("busy_after_start", busy, 64'(bc != 0));
        check("done_after_start", done, 64'(bc == 0));
        check("read_error_cleared", read_error, 0);
        check("blocks_read_cleared", blocks_read, 0);
    endtask

    task automatic wait_done(input int limit);
        int n = 0;
        while (done_n == 0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        check("done_within_budget", 64'(done_n != 0), 1);
        repeat (3) @(negedge clk);
    endtask

    task automatic run_vec(input vec_t v);
        blocks_available = 32'(v.av);
        tready_mode = v.mode;
        err_blk = v.eblk;
        err_beat = v.ebeat;
        do_start(v.bc);
        wait_done(2000);
        check("ar_count", 64'(ar_n), 64'(v.exp_ars));
        if (v.exp_ars > 0) check("last_araddr", last_araddr, v.exp_last);
        check("beats_out", 64'(out_n), 64'(v.exp_ars * CPB));
        check("blocks_read", blocks_read, 64'(v.exp_br));
        check("read_error", read_error, 64'(v.exp_err));
        check("done_once", 64'(done_n), 1);
        check("busy_idle", busy, 0);
        err_blk = -1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        tbl[0] = '{3,  8, 0, -1, 0, 3, 64'h1200, 3, 1'b0};
        tbl[1] = '{20, 8, 2, -1, 0, 8, 64'h1700, 8, 1'b0};
        tbl[2] = '{0,  8, 0, -1, 0, 0, 64'h0,    0, 1'b0};
        tbl[3] = '{3,  8, 0,  1, 2, 3, 64'h1200, 3, 1'b1};
        tbl[4] = '{2,  8, 2, -1, 0, 2, 64'h1100, 2, 1'b0};
        tbl[5] = '{8,  8, 2, -1, 0, 8, 64'h1700, 8, 1'b0};

        sys_resetn = 0; start = 0; block_count = 0; blocks_available = 0;
        tready_mode = 0; err_blk = -1; err_beat = 0;
        ar_n = 0; out_n = 0; done_n = 0; last_araddr = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_blocks_read", blocks_read, 0);
        check("rst_read_error", read_error, 0);
        check("rst_arvalid", M_AXI_ARVALID, 0);
        check("rst_tvalid", AXIS_OUT_TVALID, 0);
        check("rst_araddr", M_AXI_ARADDR, BASE);
        sys_resetn = 1;
        repeat (4) @(posedge clk);
        #1;
        check("rready", M_AXI_RREADY, 1);
        check("arlen", M_AXI_ARLEN, 3);
        check("arsize", M_AXI_ARSIZE, 3);
        check("arburst", M_AXI_ARBURST, 1);

        for (int i = 0; i < 6; i++) run_vec(tbl[i]);

        // Capture side lags: one block, then more after a delay.
        blocks_available = 1; tready_mode = 0;
        do_start(4);
        repeat (50) @(negedge clk);
        check("stall_ar_count", 64'(ar_n), 1);
        check("stall_beats", 64'(out_n), 4);
        check("stall_blocks_read", blocks_read, 1);
        check("stall_busy", busy, 1);
        check("stall_no_done", 64'(done_n), 0);
        blocks_available = 4;
        wait_done(2000);
        check("stall_ar_final", 64'(ar_n), 4);
        check("stall_last_araddr", last_araddr, 64'h1300);
        check("stall_blocks_final", blocks_read, 4);

        // Sink blocked: credit caps outstanding reads at the FIFO depth.
        blocks_available = 8; tready_mode = 1;
        do_start(8);
        repeat (60) @(negedge clk);
        check("credit_ar_count", 64'(ar_n), 4);
        check("credit_no_beats", 64'(out_n), 0);
        check("credit_tvalid", AXIS_OUT_TVALID, 1);
        check("credit_arvalid", M_AXI_ARVALID, 0);
        tready_mode = 0;
        wait_done(2000);
        check("credit_ar_final", 64'(ar_n), 8);
        check("credit_beats_final", 64'(out_n), 32);
        check("credit_blocks_final", blocks_read, 8);

        // Reset in the middle of a burst.
        tready_mode = 0;
        do_start(5);
        n = 0;
        while (out_n < 6 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("midrst_progress", 64'(out_n >= 6), 1);
        @(posedge clk);
        #2;
        sys_resetn = 0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_blocks_read", blocks_read, 0);
        check("midrst_read_error", read_error, 0);
        check("midrst_arvalid", M_AXI_ARVALID, 0);
        check("midrst_tvalid", AXIS_OUT_TVALID, 0);
        check("midrst_araddr", M_AXI_ARADDR, BASE);
        check("midrst_rready", M_AXI_RREADY, 0);
        repeat (3) @(posedge clk);
        #1;
        sys_resetn = 1;
        repeat (4) @(posedge clk);
        run_vec('{2, 8, 0, -1, 0, 2, 64'h1100, 2, 1'b0});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
